// File: rtl/ram_fill_ctrl_pkg.sv
// ram_fill_pkg: shared types and width helpers for the RAM fill controller.
//   fill_state_e : controller states (COLLECT, WRITE, FULL)
//   word_w()     : RAM word width from nibble width and nibbles per word
//   nib_cnt_w()  : width of a counter that holds 0..NIBS_PER_WORD
//   PAR_W        : 1 when RAM_FILL_PARITY_EN is defined (parity bit on ram_din), else 0
package ram_fill_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  function automatic int word_w(input int nib_w, input int nibs_per_word);
    return nib_w * nibs_per_word;
  endfunction

  function automatic int nib_cnt_w(input int nibs_per_word);
    return $clog2(nibs_per_word + 1);
  endfunction

`ifdef RAM_FILL_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/ram_fill_ctrl_if.sv
// ram_fill_ctrl_if: nibble stream in, RAM write port out.
//   nib_valid/nib_data/nib_ready : nibble handshake (accept = valid && ready)
//   flush                        : commit the partial word, zero-padded
//   ram_we/ram_addr/ram_din      : single-cycle RAM write strobe, address, data
//   master : nibble source / RAM side (testbench, receive path)
//   slave  : the fill controller
interface ram_fill_ctrl_if #(
  parameter int NIB_W  = 4,
  parameter int ADDR_W = 5,
  parameter int DIN_W  = 8
);
  logic              nib_valid;
  logic [NIB_W-1:0]  nib_data;
  logic              nib_ready;
  logic              flush;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DIN_W-1:0]  ram_din;

  modport master (
    output nib_valid, nib_data, flush,
    input  nib_ready, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  nib_valid, nib_data, flush,
    output nib_ready, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_fill_ctrl_packer.sv
// nibble_packer: shifts accepted nibbles into a word, first nibble ending in
// the MSBs, and flags when a word is complete.
//   clk, reset (sync, active-high), clear (sync restart, discards partial word)
//   accept    : a nibble is taken this cycle
//   nib_data  : nibble to take
//   flush     : close the current partial word (after any same-cycle accept)
//   word_done : combinational; a word completes on this cycle's edge
//   word      : combinational; the completed word, MSB-aligned, low nibbles zero
module nibble_packer
  import ram_fill_pkg::*;
#(
  parameter int NIB_W         = 4,
  parameter int NIBS_PER_WORD = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             accept,
  input  logic [NIB_W-1:0]                 nib_data,
  input  logic                             flush,
  output logic                             word_done,
  output logic [NIB_W*NIBS_PER_WORD-1:0]   word
);
  localparam int WORD_W = word_w(NIB_W, NIBS_PER_WORD);
  localparam int CNT_W  = nib_cnt_w(NIBS_PER_WORD);

  logic [WORD_W-1:0] sr_q, sr_d, sr_acc;
  logic [CNT_W-1:0]  nib_cnt_q, nib_cnt_d, cnt_acc;

  always_comb begin
    sr_acc  = sr_q;
    cnt_acc = nib_cnt_q;
    if (accept) begin
      sr_acc  = (sr_q << NIB_W) | WORD_W'(nib_data);
      cnt_acc = nib_cnt_q + 1'b1;
    end

    word_done = (cnt_acc == CNT_W'(NIBS_PER_WORD)) || (flush && (cnt_acc != '0));
    // Nibbles sit right-aligned while collecting; shifting left by the
    // missing count both MSB-aligns them and zero-fills the tail.
    word = sr_acc << (NIB_W * (NIBS_PER_WORD - int'(cnt_acc)));

    sr_d      = sr_acc;
    nib_cnt_d = cnt_acc;
    if (word_done || clear) begin
      sr_d      = '0;
      nib_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      nib_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end
endmodule

// File: rtl/ram_fill_ctrl.sv
// ram_fill_ctrl: packs a nibble stream into RAM words and writes them at
// consecutive addresses modulo DEPTH; stops with full (WRAP=0) or wraps (WRAP=1).
//   clk, reset (sync, active-high)
//   clear      : sync restart to address 0, partial word dropped, full cleared
//   bus        : ram_fill_ctrl_if.slave (nibble handshake, flush, RAM write port)
//   full       : buffer full, WRAP=0 only
//   wrapped    : one-cycle pulse when the address returns to 0, WRAP=1 only
//   word_count : words written since reset/clear, saturating at DEPTH
// Optional: RAM_FILL_PARITY_EN adds an even-parity MSB to ram_din.
module ram_fill_ctrl
  import ram_fill_pkg::*;
#(
  parameter int NIB_W         = 4,
  parameter int NIBS_PER_WORD = 2,
  parameter int ADDR_W        = 5,
  parameter int DEPTH         = 32,
  parameter int WRAP          = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  ram_fill_ctrl_if.slave      bus,
  output logic                full,
  output logic                wrapped,
  output logic [ADDR_W:0]     word_count
);
  localparam int WORD_W = word_w(NIB_W, NIBS_PER_WORD);
  localparam int DIN_W  = WORD_W + PAR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              ram_we_q, ram_we_d;
  logic [DIN_W-1:0]  ram_din_q, ram_din_d;
  logic              full_q, full_d;
  logic              wrapped_q, wrapped_d;

  logic              nib_ready;
  logic              accept;
  logic              flush_en;
  logic              word_done;
  logic [WORD_W-1:0] packed_word;
  logic [DIN_W-1:0]  din_word;

  assign nib_ready = (state_q == COLLECT);
  assign accept    = bus.nib_valid && nib_ready;
  assign flush_en  = bus.flush && (state_q == COLLECT);

  nibble_packer #(
    .NIB_W         (NIB_W),
    .NIBS_PER_WORD (NIBS_PER_WORD)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .nib_data  (bus.nib_data),
    .flush     (flush_en),
    .word_done (word_done),
    .word      (packed_word)
  );

`ifdef RAM_FILL_PARITY_EN
  assign din_word = {^packed_word, packed_word};
`else
  assign din_word = packed_word;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    ram_we_d     = 1'b0;
    ram_din_d    = ram_din_q;
    full_d       = full_q;
    wrapped_d    = 1'b0;

    if (clear) begin
      // A strobe already on the bus this cycle still lands; only its
      // address advance and count are dropped here.
      state_d      = COLLECT;
      addr_d       = '0;
      word_count_d = '0;
      full_d       = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (word_done) begin
            state_d   = WRITE;
            ram_we_d  = 1'b1;
            ram_din_d = din_word;
          end
        end
        WRITE: begin
          if (word_count_q != DEPTH_CNT) word_count_d = word_count_q + 1'b1;
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            state_d = COLLECT;
          end else if (WRAP != 0) begin
            addr_d    = '0;
            wrapped_d = 1'b1;
            state_d   = COLLECT;
          end else begin
            state_d = FULL;
            full_d  = 1'b1;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      addr_q       <= '0;
      word_count_q <= '0;
      ram_we_q     <= 1'b0;
      ram_din_q    <= '0;
      full_q       <= 1'b0;
      wrapped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      ram_we_q     <= ram_we_d;
      ram_din_q    <= ram_din_d;
      full_q       <= full_d;
      wrapped_q    <= wrapped_d;
    end
  end

  assign bus.nib_ready = nib_ready;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = ram_din_q;
  assign full          = full_q;
  assign wrapped       = wrapped_q;
  assign word_count    = word_count_q;
endmodule

// File: tb/tb_ram_fill_ctrl.sv
// tb_ram_fill_ctrl: three controller instances (defaults; WRAP=1/DEPTH=4;
// NIBS_PER_WORD=4) driven by directed and random nibble streams and checked
// against a stream-level model of the expected RAM writes.
module tb_ram_fill_ctrl;
`ifdef RAM_FILL_PARITY_EN
  localparam int TB_PAR = 1;
`else
  localparam int TB_PAR = 0;
`endif

  logic clk, reset;
  logic d_clear, w_clear, n_clear;
  logic d_full, w_full, n_full;
  logic d_wrapped, w_wrapped, n_wrapped;
  logic [5:0] d_wc, w_wc, n_wc;

  int vectors = 0;
  int miscompares = 0;

  ram_fill_ctrl_if #(.NIB_W(4), .ADDR_W(5), .DIN_W(8 + TB_PAR))  if_d ();
  ram_fill_ctrl_if #(.NIB_W(4), .ADDR_W(5), .DIN_W(8 + TB_PAR))  if_w ();
  ram_fill_ctrl_if #(.NIB_W(4), .ADDR_W(5), .DIN_W(16 + TB_PAR)) if_n ();

  ram_fill_ctrl #(.NIB_W(4), .NIBS_PER_WORD(2), .ADDR_W(5), .DEPTH(32), .WRAP(0)) u_def (
    .clk(clk), .reset(reset), .clear(d_clear), .bus(if_d.slave),
    .full(d_full), .wrapped(d_wrapped), .word_count(d_wc));
  ram_fill_ctrl #(.NIB_W(4), .NIBS_PER_WORD(2), .ADDR_W(5), .DEPTH(4), .WRAP(1)) u_wrp (
    .clk(clk), .reset(reset), .clear(w_clear), .bus(if_w.slave),
    .full(w_full), .wrapped(w_wrapped), .word_count(w_wc));
  ram_fill_ctrl #(.NIB_W(4), .NIBS_PER_WORD(4), .ADDR_W(5), .DEPTH(32), .WRAP(0)) u_n4 (
    .clk(clk), .reset(reset), .clear(n_clear), .bus(if_n.slave),
    .full(n_full), .wrapped(n_wrapped), .word_count(n_wc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [16:0] din;
    logic        full;
    logic        wrapped;
    logic [5:0]  wc;
    logic        ready;
  } obs_t;

  function automatic obs_t obs(input int sel);
    obs_t o;
    case (sel)
      0: begin
        o.we = if_d.ram_we; o.addr = if_d.ram_addr; o.din = 17'(if_d.ram_din);
        o.full = d_full; o.wrapped = d_wrapped; o.wc = d_wc; o.ready = if_d.nib_ready;
      end
      1: begin
        o.we = if_w.ram_we; o.addr = if_w.ram_addr; o.din = 17'(if_w.ram_din);
        o.full = w_full; o.wrapped = w_wrapped; o.wc = w_wc; o.ready = if_w.nib_ready;
      end
      default: begin
        o.we = if_n.ram_we; o.addr = if_n.ram_addr; o.din = 17'(if_n.ram_din);
        o.full = n_full; o.wrapped = n_wrapped; o.wc = n_wc; o.ready = if_n.nib_ready;
      end
    endcase
    return o;
  endfunction

  // Expected RAM data: the packed word, plus its even-parity bit above it when enabled.
  function automatic logic [16:0] exp_din(input logic [15:0] w, input int ww);
    logic [16:0] r;
    r = 17'(w);
    if (TB_PAR != 0) r[ww] = ^w;
    return r;
  endfunction

  // Write capture from the selected instance, plus wrap-pulse bookkeeping for u_wrp.
  int          cap_sel = 0;
  logic [4:0]  cap_a[$];
  logic [16:0] cap_d[$];
  int          wrap_cnt = 0;
  int          wrap_ok = 0;
  logic        prev_we_w = 1'b0;
  logic [4:0]  prev_addr_w = '0;

  always @(negedge clk) begin
    obs_t o;
    o = obs(cap_sel);
    if (o.we === 1'b1) begin
      cap_a.push_back(o.addr);
      cap_d.push_back(o.din);
    end
    if (w_wrapped === 1'b1) begin
      wrap_cnt++;
      if (prev_we_w === 1'b1 && prev_addr_w == 5'd3) wrap_ok++;
    end
    prev_we_w   = if_w.ram_we;
    prev_addr_w = if_w.ram_addr;
  end

  task automatic drive(input int sel, input logic v, input logic [3:0] d, input logic f);
    case (sel)
      0:       begin if_d.nib_valid = v; if_d.nib_data = d; if_d.flush = f; end
      1:       begin if_w.nib_valid = v; if_w.nib_data = d; if_w.flush = f; end
      default: begin if_n.nib_valid = v; if_n.nib_data = d; if_n.flush = f; end
    endcase
  endtask

  task automatic set_clear(input int sel, input logic v);
    case (sel)
      0:       d_clear = v;
      1:       w_clear = v;
      default: n_clear = v;
    endcase
  endtask

  task automatic idle(input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 4'h0, 1'b0);
  endtask

  // Presents a nibble (with optional flush) until accepted; returns just after the accepting edge.
  task automatic send(input int sel, input logic [3:0] d, input logic f);
    int n;
    obs_t o;
    @(negedge clk);
    drive(sel, 1'b1, d, f);
    n = 0;
    o = obs(sel);
    while (o.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      o = obs(sel);
    end
    vectors++;
    if (o.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout: dut %0d nib_ready=%b after %0d cycles, want 1", sel, o.ready, n);
    end
    @(posedge clk);
  endtask

  task automatic do_clear(input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 4'h0, 1'b0);
    set_clear(sel, 1'b1);
    @(negedge clk);
    set_clear(sel, 1'b0);
  endtask

  task automatic start_cap(input int sel);
    @(posedge clk);
    cap_sel = sel;
    cap_a.delete();
    cap_d.delete();
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      o = obs(s);
      vectors += 7;
      if (o.we !== 1'b0)     begin miscompares++; $display("FAIL reset_we: dut %0d got %b want 0", s, o.we); end
      if (o.addr !== 5'd0)   begin miscompares++; $display("FAIL reset_addr: dut %0d got %h want 0", s, o.addr); end
      if (o.din !== 17'd0)   begin miscompares++; $display("FAIL reset_din: dut %0d got %h want 0", s, o.din); end
      if (o.full !== 1'b0)   begin miscompares++; $display("FAIL reset_full: dut %0d got %b want 0", s, o.full); end
      if (o.wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_wrapped: dut %0d got %b want 0", s, o.wrapped); end
      if (o.wc !== 6'd0)     begin miscompares++; $display("FAIL reset_wc: dut %0d got %0d want 0", s, o.wc); end
      if (o.ready !== 1'b1)  begin miscompares++; $display("FAIL reset_ready: dut %0d got %b want 1", s, o.ready); end
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    obs_t o;
    start_cap(0);
    send(0, 4'hA, 1'b0);
    send(0, 4'h5, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors += 4;
    if (o.we !== 1'b1)               begin miscompares++; $display("FAIL stream_we0: got %b want 1", o.we); end
    if (o.addr !== 5'd0)             begin miscompares++; $display("FAIL stream_addr0: got %h want 0", o.addr); end
    if (o.din !== exp_din(16'hA5, 8)) begin miscompares++; $display("FAIL stream_din0: got %h want %h", o.din, exp_din(16'hA5, 8)); end
    if (o.ready !== 1'b0)            begin miscompares++; $display("FAIL stream_ready_write: got %b want 0", o.ready); end
    send(0, 4'h3, 1'b0);
    send(0, 4'hC, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors += 3;
    if (o.we !== 1'b1)               begin miscompares++; $display("FAIL stream_we1: got %b want 1", o.we); end
    if (o.addr !== 5'd1)             begin miscompares++; $display("FAIL stream_addr1: got %h want 1", o.addr); end
    if (o.din !== exp_din(16'h3C, 8)) begin miscompares++; $display("FAIL stream_din1: got %h want %h", o.din, exp_din(16'h3C, 8)); end
    idle(0);
    o = obs(0);
    vectors += 3;
    if (o.we !== 1'b0)  begin miscompares++; $display("FAIL stream_we_single: got %b want 0", o.we); end
    if (o.din !== exp_din(16'h3C, 8)) begin miscompares++; $display("FAIL stream_din_hold: got %h want %h", o.din, exp_din(16'h3C, 8)); end
    if (o.wc !== 6'd2)  begin miscompares++; $display("FAIL stream_wc: got %0d want 2", o.wc); end
  endtask

  task automatic test_full();
    obs_t o;
    logic [7:0] bytes[32];
    do_clear(0);
    start_cap(0);
    for (int i = 0; i < 32; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      send(0, bytes[i][7:4], 1'b0);
      send(0, bytes[i][3:0], 1'b0);
    end
    @(negedge clk);
    o = obs(0);
    vectors += 2;
    if (o.we !== 1'b1 || o.addr !== 5'd31) begin miscompares++; $display("FAIL full_last_write: got we=%b addr=%0d want we=1 addr=31", o.we, o.addr); end
    if (o.full !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b want 0", o.full); end
    @(negedge clk);
    o = obs(0);
    vectors += 3;
    if (o.full !== 1'b1)  begin miscompares++; $display("FAIL full_flag: got %b want 1", o.full); end
    if (o.ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", o.ready); end
    if (o.wc !== 6'd32)   begin miscompares++; $display("FAIL full_wc: got %0d want 32", o.wc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
    end
    idle(0);
    @(posedge clk);
    o = obs(0);
    vectors += 3;
    if (cap_a.size() != 32) begin miscompares++; $display("FAIL full_write_count: got %0d want 32", cap_a.size()); end
    if (o.full !== 1'b1 || o.ready !== 1'b0) begin miscompares++; $display("FAIL full_sticky: got full=%b ready=%b want full=1 ready=0", o.full, o.ready); end
    if (o.wc !== 6'd32) begin miscompares++; $display("FAIL full_wc_hold: got %0d want 32", o.wc); end
    for (int i = 0; i < 32 && i < cap_a.size(); i++) begin
      vectors++;
      if (cap_a[i] !== 5'(i) || cap_d[i] !== exp_din(16'(bytes[i]), 8)) begin
        miscompares++;
        $display("FAIL full_word%0d: got @%0d %h want @%0d %h", i, cap_a[i], cap_d[i], i, exp_din(16'(bytes[i]), 8));
      end
    end
    do_clear(0);
    o = obs(0);
    vectors += 3;
    if (o.full !== 1'b0)  begin miscompares++; $display("FAIL clear_full: got %b want 0", o.full); end
    if (o.wc !== 6'd0)    begin miscompares++; $display("FAIL clear_wc: got %0d want 0", o.wc); end
    if (o.ready !== 1'b1) begin miscompares++; $display("FAIL clear_ready: got %b want 1", o.ready); end
    send(0, 4'h1, 1'b0);
    send(0, 4'h2, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors++;
    if (o.we !== 1'b1 || o.addr !== 5'd0 || o.din !== exp_din(16'h12, 8)) begin
      miscompares++;
      $display("FAIL clear_rewrite: got we=%b @%0d %h want we=1 @0 %h", o.we, o.addr, o.din, exp_din(16'h12, 8));
    end
    idle(0);
    o = obs(0);
    vectors++;
    if (o.wc !== 6'd1) begin miscompares++; $display("FAIL clear_wc_inc: got %0d want 1", o.wc); end
  endtask

  task automatic test_wrap();
    obs_t o;
    logic [7:0] bytes[5];
    do_clear(1);
    start_cap(1);
    wrap_cnt = 0;
    wrap_ok  = 0;
    for (int i = 0; i < 5; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      send(1, bytes[i][7:4], 1'b0);
      send(1, bytes[i][3:0], 1'b0);
    end
    idle(1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    o = obs(1);
    vectors += 4;
    if (cap_a.size() != 5) begin miscompares++; $display("FAIL wrap_write_count: got %0d want 5", cap_a.size()); end
    if (wrap_cnt != 1)     begin miscompares++; $display("FAIL wrap_pulses: got %0d want 1", wrap_cnt); end
    if (wrap_ok != 1)      begin miscompares++; $display("FAIL wrap_pulse_timing: got %0d pulses after @3 write want 1", wrap_ok); end
    if (o.wc !== 6'd4)     begin miscompares++; $display("FAIL wrap_wc_sat: got %0d want 4", o.wc); end
    for (int i = 0; i < 5 && i < cap_a.size(); i++) begin
      vectors++;
      if (cap_a[i] !== 5'(i % 4) || cap_d[i] !== exp_din(16'(bytes[i]), 8)) begin
        miscompares++;
        $display("FAIL wrap_word%0d: got @%0d %h want @%0d %h", i, cap_a[i], cap_d[i], i % 4, exp_din(16'(bytes[i]), 8));
      end
    end
  endtask

  task automatic test_flush();
    obs_t o;
    do_clear(2);
    start_cap(2);
    send(2, 4'h7, 1'b1);
    @(negedge clk);
    o = obs(2);
    vectors++;
    if (o.we !== 1'b1 || o.addr !== 5'd0 || o.din !== exp_din(16'h7000, 16)) begin
      miscompares++;
      $display("FAIL flush_pad: got we=%b @%0d %h want we=1 @0 %h", o.we, o.addr, o.din, exp_din(16'h7000, 16));
    end
    drive(2, 1'b0, 4'h0, 1'b1);
    repeat (3) @(negedge clk);
    drive(2, 1'b0, 4'h0, 1'b0);
    send(2, 4'h1, 1'b0);
    send(2, 4'h2, 1'b0);
    @(negedge clk);
    drive(2, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    drive(2, 1'b0, 4'h0, 1'b0);
    o = obs(2);
    vectors++;
    if (o.we !== 1'b1 || o.addr !== 5'd1 || o.din !== exp_din(16'h1200, 16)) begin
      miscompares++;
      $display("FAIL flush_alone: got we=%b @%0d %h want we=1 @1 %h", o.we, o.addr, o.din, exp_din(16'h1200, 16));
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    vectors++;
    if (cap_a.size() != 2) begin miscompares++; $display("FAIL flush_empty_ignored: got %0d writes want 2", cap_a.size()); end
  endtask

  task automatic test_clear_partial();
    obs_t o;
    do_clear(0);
    start_cap(0);
    send(0, 4'h9, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 1'b0);
    set_clear(0, 1'b1);
    @(negedge clk);
    set_clear(0, 1'b0);
    send(0, 4'h1, 1'b0);
    send(0, 4'h2, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors++;
    if (o.we !== 1'b1 || o.addr !== 5'd0 || o.din !== exp_din(16'h12, 8)) begin
      miscompares++;
      $display("FAIL clear_partial: got we=%b @%0d %h want we=1 @0 %h", o.we, o.addr, o.din, exp_din(16'h12, 8));
    end
    send(0, 4'h9, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(0, 4'h1, 1'b0);
    send(0, 4'h2, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors++;
    if (o.we !== 1'b1 || o.addr !== 5'd0 || o.din !== exp_din(16'h12, 8)) begin
      miscompares++;
      $display("FAIL reset_partial: got we=%b @%0d %h want we=1 @0 %h", o.we, o.addr, o.din, exp_din(16'h12, 8));
    end
    idle(0);
    @(posedge clk);
    vectors++;
    if (cap_a.size() != 2) begin miscompares++; $display("FAIL partial_write_count: got %0d want 2", cap_a.size()); end
  endtask

  task automatic test_parity();
    obs_t o;
    logic [16:0] want07, want03;
    want07 = (TB_PAR != 0) ? 17'h107 : 17'h007;
    want03 = 17'h003;
    do_clear(0);
    send(0, 4'h0, 1'b0);
    send(0, 4'h7, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors++;
    if (o.din !== want07) begin miscompares++; $display("FAIL parity_07: got %h want %h", o.din, want07); end
    send(0, 4'h0, 1'b0);
    send(0, 4'h3, 1'b0);
    @(negedge clk);
    o = obs(0);
    vectors++;
    if (o.din !== want03) begin miscompares++; $display("FAIL parity_03: got %h want %h", o.din, want03); end
    idle(0);
  endtask

  // Random nibbles, gaps and flushes; the model groups accepted nibbles into
  // words and places word k at address k mod depth.
  task automatic test_random(input int sel, input int npw, input int depth, input bit wrap, input int nnib);
    obs_t o;
    logic [15:0] exp_w[$];
    logic [15:0] part;
    logic [3:0]  d;
    logic        f;
    int          pc, nexp, ncnt;
    do_clear(sel);
    start_cap(sel);
    part = '0;
    pc = 0;
    for (int i = 0; i < nnib; i++) begin
      d = 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) idle(sel);
      send(sel, d, f);
      part = (part << 4) | 16'(d);
      pc++;
      if (pc == npw) begin
        exp_w.push_back(part);
        part = '0; pc = 0;
      end else if (f) begin
        exp_w.push_back(part << (4 * (npw - pc)));
        part = '0; pc = 0;
      end
    end
    idle(sel);
    repeat (3) @(negedge clk);
    @(posedge clk);
    nexp = (wrap || exp_w.size() < depth) ? exp_w.size() : depth;
    ncnt = (exp_w.size() < depth) ? exp_w.size() : depth;
    o = obs(sel);
    vectors += 2;
    if (cap_a.size() != nexp) begin miscompares++; $display("FAIL rand_count: dut %0d got %0d writes want %0d", sel, cap_a.size(), nexp); end
    if (o.wc !== 6'(ncnt))   begin miscompares++; $display("FAIL rand_wc: dut %0d got %0d want %0d", sel, o.wc, ncnt); end
    for (int k = 0; k < nexp && k < cap_a.size(); k++) begin
      vectors++;
      if (cap_a[k] !== 5'(k % depth) || cap_d[k] !== exp_din(exp_w[k], npw * 4)) begin
        miscompares++;
        $display("FAIL rand_word: dut %0d #%0d got @%0d %h want @%0d %h", sel, k, cap_a[k], cap_d[k], k % depth, exp_din(exp_w[k], npw * 4));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    d_clear = 1'b0; w_clear = 1'b0; n_clear = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 4'h0, 1'b0);
    test_reset();
    test_stream();
    test_full();
    test_wrap();
    test_flush();
    test_clear_partial();
    test_parity();
    test_random(0, 2, 32, 1'b0, 30);
    test_random(1, 2, 4, 1'b1, 60);
    test_random(2, 4, 32, 1'b0, 40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_fill_ctrl.md
# ram_fill_ctrl

Parametrised RAM fill controller. It packs a stream of narrow nibbles (MSB-first) into RAM words and issues one-cycle write strobes at consecutive addresses. At the end of the buffer it either stops and reports full, or wraps around. It sits between the slave's nibble receive path and the dual-port capture RAM, replacing the fixed 4-bit/8-bit/32-entry fill logic.

## Interface
- `NIB_W`, 4: width of one input nibble.
- `NIBS_PER_WORD`, 2: nibbles per RAM word (≥1); `WORD_W = NIB_W*NIBS_PER_WORD`.
- `ADDR_W`, 5: RAM address width.
- `DEPTH`, 32: words in buffer; 2 ≤ DEPTH ≤ 2^ADDR_W.
- `WRAP`, 0: 0 = stop at DEPTH and assert full; 1 = wrap to address 0 and continue.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high; clock clk.
- `clear`, in, 1: synchronous restart; address 0, partial word discarded, full cleared.
- `nib_valid`, in, 1: `nib_data` valid.
- `nib_data`, in, NIB_W: input nibble.
- `nib_ready`, out, 1: controller accepts a nibble this cycle.
- `flush`, in, 1: commit a partial word, zero-padding the missing low nibbles.
- `ram_we`, out, 1: single-cycle write strobe.
- `ram_addr`, out, ADDR_W: write address.
- `ram_din`, out, WORD_W (+1 with parity): write data.
- `full`, out, 1: buffer full (WRAP=0 only).
- `wrapped`, out, 1: one-cycle pulse when the address returns to 0 (WRAP=1 only).
- `word_count`, out, ADDR_W+1: words written since reset/clear, saturating at DEPTH.

## Operation
- States: COLLECT, WRITE, FULL.
- A nibble is accepted when `nib_valid && nib_ready`. `nib_ready` = 1 only in COLLECT.
- COLLECT:
  - On accept, shift the nibble into the packer, first nibble into the MSBs, and increment `nib_cnt`.
  - On the accept of nibble `NIBS_PER_WORD-1`, go to WRITE.
  - If `flush` is high and `nib_cnt` > 0 after any same-cycle accept, go to WRITE with the low nibbles zero-padded. An accept in the same cycle is included before padding.
  - `flush` with `nib_cnt` = 0 and no accept is ignored.
- WRITE:
  - `ram_we` = 1 for exactly one cycle; `ram_addr` is the current word address and `ram_din` the packed word.
  - Then `nib_cnt` ← 0 and `word_count` increments (saturating).
  - If `ram_addr` < DEPTH-1: increment the address and go to COLLECT.
  - If `ram_addr` = DEPTH-1 and WRAP=1: address ← 0, pulse `wrapped`, go to COLLECT.
  - If `ram_addr` = DEPTH-1 and WRAP=0: go to FULL.
- FULL: `full` = 1, `nib_ready` = 0, `nib_valid` and `flush` ignored. Leaves only on `clear` or `reset`.
- `clear` acts in any state: go to COLLECT, address 0, `nib_cnt` 0, `word_count` 0, `full` 0. A write in progress that cycle is still strobed, but its address advance is discarded.
- Priority: reset > clear > flush/accept.
- Address arithmetic is modulo DEPTH, never modulo 2^ADDR_W.

## Timing
- Reset values: `ram_we` 0, `ram_addr` 0, `ram_din` 0, `full` 0, `wrapped` 0, `word_count` 0, `nib_ready` 1 (state COLLECT).
- All outputs are registered except `nib_ready`, which is decoded from the state.
- Latency: the last nibble is accepted in cycle N; `ram_we` is high in cycle N+1.
- Throughput: one word per NIBS_PER_WORD+1 cycles with continuous valid.
- `ram_addr` and `ram_din` are stable during the `ram_we` cycle. `ram_din` holds its value after the write until the next write.
- `full` rises the cycle after the last `ram_we`.

## Configuration
- `RAM_FILL_PARITY_EN` defined:
  - `ram_din` is WORD_W+1 bits, with the MSB set to the even parity of the packed word (padding included).
- Undefined:
  - `ram_din` is WORD_W bits and there is no parity logic.

## Structure
- Package `ram_fill_pkg`:
  - state enum (COLLECT, WRITE, FULL);
  - `WORD_W` and `NIB_CNT_W = $clog2(NIBS_PER_WORD+1)` derivation helpers.
- Sub-module `nibble_packer`: shift register, `nib_cnt`, zero-pad on flush, and a `word_done` output. The top level holds the FSM, address counter and `word_count`.

## Test plan
- Defaults, nibbles 0xA,0x5,0x3,0xC streamed back-to-back -> writes 0xA5 @0, 0x3C @1; each `ram_we` is one cycle after the 2nd nibble.
- Defaults, WRAP=0, 32 bytes written -> last write @31, `full` = 1, `nib_ready` = 0; a 33rd nibble is ignored; `clear` -> next write @0, `word_count` 0→1.
- WRAP=1, DEPTH=4, 5 bytes written -> addresses 0,1,2,3,0; `wrapped` pulses once after the @3 write; `word_count` saturates at 4.
- NIBS_PER_WORD=4, nibble 0x7 then `flush` -> writes 0x7000; `flush` with `nib_cnt` 0 -> no write.
- `reset` or `clear` after one nibble is accepted -> partial word discarded; next pair 0x1,0x2 writes 0x12 @0.
- `RAM_FILL_PARITY_EN`, byte 0x07 -> `ram_din` = 9'h107; byte 0x03 -> 9'h003.
